// File: rtl/time_set_if.sv
// Button, tick and display bundle for time_set_ctrl.
// master: the side that drives the buttons and the tick and reads the display.
// slave:  the time-keeping controller.
interface time_set_if;
  logic       mode_pb;
  logic       inc_pb;
  logic       tick_1hz;
  logic [4:0] hours;
  logic [5:0] minutes;
  logic [5:0] seconds;
  logic [1:0] mode;
  logic       blink;

  modport master (
    output mode_pb, inc_pb, tick_1hz,
    input  hours, minutes, seconds, mode, blink
  );

  modport slave (
    input  mode_pb, inc_pb, tick_1hz,
    output hours, minutes, seconds, mode, blink
  );
endinterface

// File: rtl/time_set_ctrl.sv
// time_set_ctrl: 24-hour clock that runs from a 1 Hz tick and can be set
// with two debounced buttons (mode, increment).
// Mode cycles RUN -> SET_HR -> SET_MIN -> RUN. While a field is being set,
// timekeeping is frozen and the tick only toggles the blink strobe.
// Optional macro AUTO_REPEAT_EN: a held increment button repeats once per
// tick after two full ticks of holding (SET_HR / SET_MIN only).
module time_set_ctrl #(
  parameter int unsigned RESET_HOUR = 12
) (
  input  logic        clk_in,
  input  logic        rst_n,
  time_set_if.slave   bus
);

  typedef enum logic [1:0] {
    ST_RUN     = 2'b00,
    ST_SET_HR  = 2'b01,
    ST_SET_MIN = 2'b10,
    ST_ILLEGAL = 2'b11
  } state_t;

  logic [1:0] mode_sync;
  logic [1:0] inc_sync;
  logic       mode_prev;
  logic       inc_prev;
  logic       mode_ev;
  logic       inc_ev;
  logic       inc_held;
  logic       rep_inc;

  state_t     state_q, state_n;
  logic [4:0] hours_q, hours_n;
  logic [5:0] min_q,   min_n;
  logic [5:0] sec_q,   sec_n;
  logic       blink_q, blink_n;

  // Two-flop synchronizers plus previous-value flops for rising-edge detection
  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      mode_sync <= '0;
      inc_sync  <= '0;
      mode_prev <= 1'b0;
      inc_prev  <= 1'b0;
    end else begin
      mode_sync <= {mode_sync[0], bus.mode_pb};
      inc_sync  <= {inc_sync[0],  bus.inc_pb};
      mode_prev <= mode_sync[1];
      inc_prev  <= inc_sync[1];
    end
  end

  assign mode_ev  = mode_sync[1] & ~mode_prev;
  assign inc_ev   = inc_sync[1]  & ~inc_prev;
  assign inc_held = inc_sync[1];

`ifdef AUTO_REPEAT_EN
  logic [1:0] rep_cnt_q;

  // Count full ticks while inc is held in a set state; saturates at two
  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      rep_cnt_q <= '0;
    end else if (!inc_held || mode_ev ||
                 !(state_q == ST_SET_HR || state_q == ST_SET_MIN)) begin
      rep_cnt_q <= '0;
    end else if (bus.tick_1hz && rep_cnt_q != 2'd2) begin
      rep_cnt_q <= rep_cnt_q + 2'd1;
    end
  end

  assign rep_inc = bus.tick_1hz & inc_held & (rep_cnt_q == 2'd2);
`else
  assign rep_inc = 1'b0 & inc_held;
`endif

  // State and time registers
  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_RUN;
      hours_q <= 5'(RESET_HOUR);
      min_q   <= '0;
      sec_q   <= '0;
      blink_q <= 1'b0;
    end else begin
      state_q <= state_n;
      hours_q <= hours_n;
      min_q   <= min_n;
      sec_q   <= sec_n;
      blink_q <= blink_n;
    end
  end

  // Next-state, timekeeping and edit logic; a mode event wins over inc,
  // while a coincident tick is applied in the pre-transition state
  always_comb begin
    state_n = state_q;
    hours_n = hours_q;
    min_n   = min_q;
    sec_n   = sec_q;
    blink_n = blink_q;

    case (state_q)
      ST_RUN: begin
        blink_n = 1'b0;
        if (bus.tick_1hz) begin
          if (sec_q == 6'd59) begin
            sec_n = '0;
            if (min_q == 6'd59) begin
              min_n   = '0;
              hours_n = (hours_q == 5'd23) ? 5'd0 : hours_q + 5'd1;
            end else begin
              min_n = min_q + 6'd1;
            end
          end else begin
            sec_n = sec_q + 6'd1;
          end
        end
        if (mode_ev) begin
          state_n = ST_SET_HR;
        end
      end

      ST_SET_HR: begin
        if (bus.tick_1hz) begin
          blink_n = ~blink_q;
        end
        if (mode_ev) begin
          state_n = ST_SET_MIN;
          blink_n = 1'b0;
        end else if (inc_ev || rep_inc) begin
          hours_n = (hours_q == 5'd23) ? 5'd0 : hours_q + 5'd1;
        end
      end

      ST_SET_MIN: begin
        if (bus.tick_1hz) begin
          blink_n = ~blink_q;
        end
        if (mode_ev) begin
          state_n = ST_RUN;
          blink_n = 1'b0;
          sec_n   = '0;
        end else if (inc_ev || rep_inc) begin
          min_n = (min_q == 6'd59) ? 6'd0 : min_q + 6'd1;
        end
      end

      default: begin
        state_n = ST_RUN;
        blink_n = 1'b0;
      end
    endcase
  end

  assign bus.hours   = hours_q;
  assign bus.minutes = min_q;
  assign bus.seconds = sec_q;
  assign bus.mode    = state_q;
  assign bus.blink   = blink_q;

endmodule

// File: tb/tb_time_set_ctrl.sv
// Directed bench for time_set_ctrl: reset, run ticks, mode sequencing and
// latency, hour/minute edit wrap, blink, same-cycle mode/inc, full-day
// rollover, tick coinciding with mode, auto-repeat, reset mid-edit.
module tb_time_set_ctrl;

  logic clk;
  logic rst_n;
  int   n_cmp;
  int   n_err;
  int   cur_min;

  time_set_if bus();

  time_set_ctrl #(.RESET_HOUR(12)) dut (
    .clk_in (clk),
    .rst_n  (rst_n),
    .bus    (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic press_mode();
    @(negedge clk);
    bus.mode_pb = 1'b1;
    cyc(3);
    bus.mode_pb = 1'b0;
    cyc(3);
  endtask

  task automatic press_inc(input int n);
    repeat (n) begin
      @(negedge clk);
      bus.inc_pb = 1'b1;
      cyc(3);
      bus.inc_pb = 1'b0;
      cyc(3);
    end
  endtask

  task automatic pulse_tick();
    @(negedge clk);
    bus.tick_1hz = 1'b1;
    @(negedge clk);
    bus.tick_1hz = 1'b0;
    cyc(1);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    bus.mode_pb = 1'b0;
    bus.inc_pb = 1'b0;
    bus.tick_1hz = 1'b0;
    #23;
    n_cmp++;
    if ({bus.hours, bus.minutes, bus.seconds} !== {5'd12, 6'd0, 6'd0}) begin
      n_err++;
      $display("FAIL reset_time got %0d:%0d:%0d want 12:0:0", bus.hours, bus.minutes, bus.seconds);
    end
    n_cmp++;
    if ({bus.mode, bus.blink} !== 3'b000) begin
      n_err++;
      $display("FAIL reset_mode_blink got %b/%b want 00/0", bus.mode, bus.blink);
    end
    @(negedge clk);
    rst_n = 1'b1;
    cyc(2);
  endtask

  task automatic test_run_ticks();
    repeat (3) pulse_tick();
    n_cmp++;
    if ({bus.hours, bus.minutes, bus.seconds} !== {5'd12, 6'd0, 6'd3}) begin
      n_err++;
      $display("FAIL run_3ticks got %0d:%0d:%0d want 12:0:3", bus.hours, bus.minutes, bus.seconds);
    end
    n_cmp++;
    if ({bus.mode, bus.blink} !== 3'b000) begin
      n_err++;
      $display("FAIL run_mode_blink got %b/%b want 00/0", bus.mode, bus.blink);
    end
  endtask

  task automatic test_mode_press();
    @(negedge clk);
    bus.mode_pb = 1'b1;
    @(posedge clk);           // edge k
    @(posedge clk); #1;       // edge k+1
    n_cmp++;
    if (bus.mode !== 2'b00) begin
      n_err++;
      $display("FAIL mode_k1 got %b want 00", bus.mode);
    end
    @(posedge clk); #1;       // edge k+2
    n_cmp++;
    if (bus.mode !== 2'b01) begin
      n_err++;
      $display("FAIL mode_k2 got %b want 01", bus.mode);
    end
    cyc(37);
    bus.mode_pb = 1'b0;
    cyc(4);
    n_cmp++;
    if (bus.mode !== 2'b01) begin
      n_err++;
      $display("FAIL mode_long_hold got %b want 01", bus.mode);
    end
    press_mode();
    n_cmp++;
    if (bus.mode !== 2'b10) begin
      n_err++;
      $display("FAIL mode_second got %b want 10", bus.mode);
    end
    pulse_tick();
    n_cmp++;
    if (bus.seconds !== 6'd3 || bus.blink !== 1'b1) begin
      n_err++;
      $display("FAIL set_min_tick got sec=%0d blink=%b want sec=3 blink=1", bus.seconds, bus.blink);
    end
    press_mode();
    n_cmp++;
    if ({bus.mode, bus.blink} !== 3'b000 ||
        {bus.hours, bus.minutes, bus.seconds} !== {5'd12, 6'd0, 6'd0}) begin
      n_err++;
      $display("FAIL mode_third got mode=%b blink=%b %0d:%0d:%0d want 00/0 12:0:0",
               bus.mode, bus.blink, bus.hours, bus.minutes, bus.seconds);
    end
  endtask

  task automatic test_set_hr_wrap();
    press_mode();
    press_inc(11);
    n_cmp++;
    if (bus.hours !== 5'd23 || bus.mode !== 2'b01) begin
      n_err++;
      $display("FAIL set_hr_to23 got hours=%0d mode=%b want 23/01", bus.hours, bus.mode);
    end
    press_inc(1);
    n_cmp++;
    if (bus.hours !== 5'd0 || bus.minutes !== 6'd0) begin
      n_err++;
      $display("FAIL set_hr_wrap got %0d:%0d want 0:0", bus.hours, bus.minutes);
    end
    for (int i = 0; i < 4; i++) begin
      pulse_tick();
      n_cmp++;
      if (bus.blink !== ((i % 2) == 0) || bus.seconds !== 6'd0) begin
        n_err++;
        $display("FAIL set_hr_blink%0d got blink=%b sec=%0d want blink=%b sec=0",
                 i, bus.blink, bus.seconds, ((i % 2) == 0));
      end
    end
  endtask

  task automatic test_same_cycle();
    press_inc(5);
    @(negedge clk);
    bus.mode_pb = 1'b1;
    bus.inc_pb = 1'b1;
    cyc(3);
    bus.mode_pb = 1'b0;
    bus.inc_pb = 1'b0;
    cyc(3);
    n_cmp++;
    if (bus.mode !== 2'b10 || bus.hours !== 5'd5) begin
      n_err++;
      $display("FAIL same_cycle got mode=%b hours=%0d want 10/5", bus.mode, bus.hours);
    end
  endtask

  task automatic test_auto_repeat();
    press_inc(10);
    n_cmp++;
    if (bus.minutes !== 6'd10) begin
      n_err++;
      $display("FAIL set_min_to10 got %0d want 10", bus.minutes);
    end
    @(negedge clk);
    bus.inc_pb = 1'b1;
    cyc(3);
    repeat (5) begin
      pulse_tick();
      cyc(1);
    end
    bus.inc_pb = 1'b0;
    cyc(3);
`ifdef AUTO_REPEAT_EN
    cur_min = 14;
`else
    cur_min = 11;
`endif
    n_cmp++;
    if (bus.minutes !== 6'(cur_min)) begin
      n_err++;
      $display("FAIL hold_inc got %0d want %0d", bus.minutes, cur_min);
    end
    press_mode();
    n_cmp++;
    if ({bus.hours, bus.minutes, bus.seconds} !== {5'd5, 6'(cur_min), 6'd0} ||
        {bus.mode, bus.blink} !== 3'b000) begin
      n_err++;
      $display("FAIL edit_exit got %0d:%0d:%0d mode=%b blink=%b want 5:%0d:0 00/0",
               bus.hours, bus.minutes, bus.seconds, bus.mode, bus.blink, cur_min);
    end
  endtask

  task automatic test_rollover();
    press_mode();
    press_inc(18);
    press_mode();
    press_inc(59 - cur_min);
    press_mode();
    n_cmp++;
    if ({bus.hours, bus.minutes, bus.seconds} !== {5'd23, 6'd59, 6'd0} || bus.mode !== 2'b00) begin
      n_err++;
      $display("FAIL preload got %0d:%0d:%0d mode=%b want 23:59:0 00",
               bus.hours, bus.minutes, bus.seconds, bus.mode);
    end
    repeat (59) pulse_tick();
    n_cmp++;
    if ({bus.hours, bus.minutes, bus.seconds} !== {5'd23, 6'd59, 6'd59}) begin
      n_err++;
      $display("FAIL pre_wrap got %0d:%0d:%0d want 23:59:59", bus.hours, bus.minutes, bus.seconds);
    end
    pulse_tick();
    n_cmp++;
    if ({bus.hours, bus.minutes, bus.seconds} !== {5'd0, 6'd0, 6'd0}) begin
      n_err++;
      $display("FAIL day_wrap got %0d:%0d:%0d want 0:0:0", bus.hours, bus.minutes, bus.seconds);
    end
  endtask

  task automatic test_tick_with_mode();
    @(negedge clk);
    bus.mode_pb = 1'b1;
    @(posedge clk);           // edge k
    @(posedge clk);           // edge k+1, event now pending for edge k+2
    @(negedge clk);
    bus.tick_1hz = 1'b1;
    @(negedge clk);
    bus.tick_1hz = 1'b0;
    bus.mode_pb = 1'b0;
    cyc(3);
    n_cmp++;
    if (bus.seconds !== 6'd1 || bus.mode !== 2'b01 || bus.blink !== 1'b0) begin
      n_err++;
      $display("FAIL tick_with_mode got sec=%0d mode=%b blink=%b want 1/01/0",
               bus.seconds, bus.mode, bus.blink);
    end
    press_mode();
    press_mode();
  endtask

  task automatic test_reset_mid_edit();
    press_mode();
    press_inc(2);
    n_cmp++;
    if (bus.hours !== 5'd2 || bus.mode !== 2'b01) begin
      n_err++;
      $display("FAIL pre_reset_edit got hours=%0d mode=%b want 2/01", bus.hours, bus.mode);
    end
    @(negedge clk);
    bus.mode_pb = 1'b1;
    bus.inc_pb = 1'b1;
    cyc(2);
    #2;
    rst_n = 1'b0;
    #1;
    n_cmp++;
    if ({bus.hours, bus.minutes, bus.seconds} !== {5'd12, 6'd0, 6'd0} ||
        {bus.mode, bus.blink} !== 3'b000) begin
      n_err++;
      $display("FAIL async_reset got %0d:%0d:%0d mode=%b blink=%b want 12:0:0 00/0",
               bus.hours, bus.minutes, bus.seconds, bus.mode, bus.blink);
    end
    cyc(2);
    rst_n = 1'b1;
    cyc(5);
    n_cmp++;
    if (bus.mode !== 2'b01 || bus.hours !== 5'd12) begin
      n_err++;
      $display("FAIL held_through_reset got mode=%b hours=%0d want 01/12", bus.mode, bus.hours);
    end
    cyc(10);
    bus.mode_pb = 1'b0;
    bus.inc_pb = 1'b0;
    cyc(4);
    n_cmp++;
    if (bus.mode !== 2'b01 || bus.hours !== 5'd12) begin
      n_err++;
      $display("FAIL single_event_after_reset got mode=%b hours=%0d want 01/12", bus.mode, bus.hours);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    n_cmp = 0;
    n_err = 0;
    cur_min = 0;
    test_reset();
    test_run_ticks();
    test_mode_press();
    test_set_hr_wrap();
    test_same_cycle();
    test_auto_repeat();
    test_rollover();
    test_tick_with_mode();
    test_reset_mid_edit();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
